// File: rtl/carfield_regbus_addr_router.sv
// rtl/carfield_regbus_addr_router.sv - single-outstanding RegBus router to the Carfield config targets
// Optional CARFIELD_REGBUS_TIMEOUT_EN: abort a hung target after TimeoutCycles forward cycles.
module carfield_regbus_addr_router #(
  parameter int unsigned NumPorts      = 4,
  parameter int unsigned AddrWidth     = 48,
  parameter int unsigned DataWidth     = 32,
  parameter logic [NumPorts-1:0][AddrWidth-1:0] PortBase = {
    AddrWidth'('h200B0000), AddrWidth'('h200A0000),
    AddrWidth'('h20020000), AddrWidth'('h20010000)},
  parameter logic [NumPorts-1:0][AddrWidth-1:0] PortSize = {NumPorts{AddrWidth'('h1000)}},
  parameter logic [NumPorts-1:0] PortEnable    = '1,
  parameter logic [DataWidth-1:0] ErrData      = DataWidth'(32'hBADCAB1E),
  parameter int unsigned TimeoutCycles = 256
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            req_valid_i,
  input  logic [AddrWidth-1:0]            req_addr_i,
  input  logic                            req_write_i,
  input  logic [DataWidth-1:0]            req_wdata_i,
  input  logic [DataWidth/8-1:0]          req_wstrb_i,
  output logic                            req_ready_o,
  output logic [DataWidth-1:0]            rsp_rdata_o,
  output logic                            rsp_error_o,
  output logic [NumPorts-1:0]             mst_valid_o,
  output logic [AddrWidth-1:0]            mst_addr_o,
  output logic                            mst_write_o,
  output logic [DataWidth-1:0]            mst_wdata_o,
  output logic [DataWidth/8-1:0]          mst_wstrb_o,
  input  logic [NumPorts-1:0]             mst_ready_i,
  input  logic [NumPorts*DataWidth-1:0]   mst_rdata_i,
  input  logic [NumPorts-1:0]             mst_error_i
);

  localparam int unsigned IdxW  = (NumPorts > 1) ? $clog2(NumPorts) : 1;
  localparam int unsigned StrbW = DataWidth / 8;

  typedef enum logic [1:0] {IDLE, FWD, RESP, ERR} state_e;

  state_e                state_q, state_d;
  logic [AddrWidth-1:0]  addr_q, addr_d;
  logic                  write_q, write_d;
  logic [DataWidth-1:0]  wdata_q, wdata_d;
  logic [StrbW-1:0]      wstrb_q, wstrb_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic                  ready_q, ready_d;
  logic [DataWidth-1:0]  rdata_q, rdata_d;
  logic                  error_q, error_d;

  logic                  hit;
  logic [IdxW-1:0]       hit_idx;
  logic                  sel_ready;
  logic [DataWidth-1:0]  sel_rdata;
  logic                  sel_error;
  logic                  timeout;

`ifdef CARFIELD_REGBUS_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  assign timeout = (cnt_q == 16'(TimeoutCycles - 1));
`else
  assign timeout = 1'b0;
`endif

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NumPorts - 1; i >= 0; i--) begin
      if (PortEnable[i] &&
          ({1'b0, req_addr_i} >= {1'b0, PortBase[i]}) &&
          ({1'b0, req_addr_i} <  ({1'b0, PortBase[i]} + {1'b0, PortSize[i]}))) begin
        hit     = 1'b1;
        hit_idx = IdxW'(i);
      end
    end
  end

  assign sel_ready = mst_ready_i[idx_q];
  assign sel_rdata = mst_rdata_i[idx_q*DataWidth +: DataWidth];
  assign sel_error = mst_error_i[idx_q];

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    idx_d   = idx_q;
    ready_d = 1'b0;
    rdata_d = '0;
    error_d = 1'b0;
`ifdef CARFIELD_REGBUS_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          addr_d  = req_addr_i;
          write_d = req_write_i;
          wdata_d = req_wdata_i;
          wstrb_d = req_wstrb_i;
          idx_d   = hit_idx;
`ifdef CARFIELD_REGBUS_TIMEOUT_EN
          cnt_d   = '0;
`endif
          if (hit) begin
            state_d = FWD;
          end else begin
            state_d = ERR;
            ready_d = 1'b1;
            rdata_d = ErrData;
            error_d = 1'b1;
          end
        end
      end
      FWD: begin
`ifdef CARFIELD_REGBUS_TIMEOUT_EN
        cnt_d = cnt_q + 16'd1;
`endif
        // A response arriving on the timeout cycle still counts as a normal response.
        if (sel_ready) begin
          state_d = RESP;
          ready_d = 1'b1;
          rdata_d = sel_rdata;
          error_d = sel_error;
        end else if (timeout) begin
          state_d = ERR;
          ready_d = 1'b1;
          rdata_d = ErrData;
          error_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      idx_q   <= '0;
      ready_q <= 1'b0;
      rdata_q <= '0;
      error_q <= 1'b0;
`ifdef CARFIELD_REGBUS_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      idx_q   <= idx_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
`ifdef CARFIELD_REGBUS_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  always_comb begin
    mst_valid_o = '0;
    if (state_q == FWD) mst_valid_o[idx_q] = 1'b1;
  end

  assign mst_addr_o  = addr_q;
  assign mst_write_o = write_q;
  assign mst_wdata_o = wdata_q;
  assign mst_wstrb_o = wstrb_q;
  assign req_ready_o = ready_q;
  assign rsp_rdata_o = rdata_q;
  assign rsp_error_o = error_q;

endmodule

// File: tb/tb_carfield_regbus_addr_router.sv
// tb/tb_carfield_regbus_addr_router.sv - randomized self-checking bench for carfield_regbus_addr_router
// Instance A uses defaults; instance B has PortEnable=4'b1011, TimeoutCycles=16.
module tb_carfield_regbus_addr_router;
  localparam int AW = 48;
  localparam int DW = 32;
  localparam int NP = 4;
  localparam logic [DW-1:0] ERR_DATA = 32'hBADCAB1E;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              valid_a, valid_b;
  logic [AW-1:0]     addr;
  logic              write;
  logic [DW-1:0]     wdata;
  logic [DW/8-1:0]   wstrb;
  logic [NP-1:0]     mst_ready;
  logic [NP*DW-1:0]  mst_rdata;
  logic [NP-1:0]     mst_error;

  logic              rdy_a, rdy_b, err_a, err_b, mw_a, mw_b;
  logic [DW-1:0]     rd_a, rd_b, mwd_a, mwd_b;
  logic [NP-1:0]     mv_a, mv_b;
  logic [AW-1:0]     ma_a, ma_b;
  logic [DW/8-1:0]   ms_a, ms_b;

  carfield_regbus_addr_router u_a (
    .clk_i(clk), .rst_i(rst), .req_valid_i(valid_a), .req_addr_i(addr),
    .req_write_i(write), .req_wdata_i(wdata), .req_wstrb_i(wstrb),
    .req_ready_o(rdy_a), .rsp_rdata_o(rd_a), .rsp_error_o(err_a),
    .mst_valid_o(mv_a), .mst_addr_o(ma_a), .mst_write_o(mw_a),
    .mst_wdata_o(mwd_a), .mst_wstrb_o(ms_a), .mst_ready_i(mst_ready),
    .mst_rdata_i(mst_rdata), .mst_error_i(mst_error)
  );

  carfield_regbus_addr_router #(.PortEnable(4'b1011), .TimeoutCycles(16)) u_b (
    .clk_i(clk), .rst_i(rst), .req_valid_i(valid_b), .req_addr_i(addr),
    .req_write_i(write), .req_wdata_i(wdata), .req_wstrb_i(wstrb),
    .req_ready_o(rdy_b), .rsp_rdata_o(rd_b), .rsp_error_o(err_b),
    .mst_valid_o(mv_b), .mst_addr_o(ma_b), .mst_write_o(mw_b),
    .mst_wdata_o(mwd_b), .mst_wstrb_o(ms_b), .mst_ready_i(mst_ready),
    .mst_rdata_i(mst_rdata), .mst_error_i(mst_error)
  );

  int sel;
  logic              o_rdy, o_err, o_mw;
  logic [DW-1:0]     o_rd, o_mwd;
  logic [NP-1:0]     o_mv;
  logic [AW-1:0]     o_ma;
  logic [DW/8-1:0]   o_ms;
  assign o_rdy = (sel == 1) ? rdy_b : rdy_a;
  assign o_err = (sel == 1) ? err_b : err_a;
  assign o_rd  = (sel == 1) ? rd_b  : rd_a;
  assign o_mv  = (sel == 1) ? mv_b  : mv_a;
  assign o_ma  = (sel == 1) ? ma_b  : ma_a;
  assign o_mw  = (sel == 1) ? mw_b  : mw_a;
  assign o_mwd = (sel == 1) ? mwd_b : mwd_a;
  assign o_ms  = (sel == 1) ? ms_b  : ms_a;

  int vectors = 0;
  int miscompares = 0;

  longint unsigned base_t [NP] = '{64'h20010000, 64'h20020000, 64'h200A0000, 64'h200B0000};
  bit [NP-1:0]     en_t [2]    = '{4'b1111, 4'b1011};

  function automatic int model_idx(input int d, input longint unsigned a);
    for (int i = 0; i < NP; i++)
      if (en_t[d][i] && a >= base_t[i] && a < base_t[i] + 64'h1000) return i;
    return -1;
  endfunction

  function automatic int fwd_limit(input int d);
`ifdef CARFIELD_REGBUS_TIMEOUT_EN
    return (d == 1) ? 16 : 256;
`else
    return 1 << 30;
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic xact(input int d, input logic [AW-1:0] a, input logic w,
                      input logic [DW-1:0] wd, input logic [DW/8-1:0] ws,
                      input int delay, input logic [DW-1:0] trd, input logic terr);
    int idx, lim, nf;
    logic [NP-1:0] exp_v;
    sel = d;
    idx = model_idx(d, 64'(a));
    lim = fwd_limit(d);
    @(negedge clk);
    addr = a; write = w; wdata = wd; wstrb = ws;
    if (d == 0) valid_a = 1'b1; else valid_b = 1'b1;
    @(posedge clk); #1;
    if (idx >= 0) begin
      exp_v = NP'(1) << idx;
      nf = (delay < lim) ? delay + 1 : lim;
      for (int c = 0; c < nf; c++) begin
        chk("mst_valid", 64'(o_mv), 64'(exp_v));
        chk("mst_addr", 64'(o_ma), 64'(a));
        chk("mst_write", 64'(o_mw), 64'(w));
        chk("mst_wdata", 64'(o_mwd), 64'(wd));
        chk("mst_wstrb", 64'(o_ms), 64'(ws));
        chk("req_ready_fwd", 64'(o_rdy), 64'd0);
        mst_ready = NP'($urandom) & ~exp_v;
        mst_rdata = {$urandom, $urandom, $urandom, $urandom};
        mst_error = NP'($urandom);
        if (c == delay) begin
          mst_ready[idx] = 1'b1;
          mst_rdata[idx*DW +: DW] = trd;
          mst_error[idx] = terr;
        end
        @(posedge clk); #1;
        mst_ready = '0;
      end
      chk("req_ready_rsp", 64'(o_rdy), 64'd1);
      chk("rsp_rdata", 64'(o_rd), (delay < lim) ? 64'(trd) : 64'(ERR_DATA));
      chk("rsp_error", 64'(o_err), (delay < lim) ? 64'(terr) : 64'd1);
    end else begin
      chk("req_ready_err", 64'(o_rdy), 64'd1);
      chk("err_rdata", 64'(o_rd), 64'(ERR_DATA));
      chk("err_error", 64'(o_err), 64'd1);
    end
    chk("mst_valid_rsp", 64'(o_mv), 64'd0);
    valid_a = 1'b0; valid_b = 1'b0;
    @(posedge clk); #1;
    chk("req_ready_after", 64'(o_rdy), 64'd0);
    chk("rdata_after", 64'(o_rd), 64'd0);
    chk("error_after", 64'(o_err), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int d, p, kind;
    logic [AW-1:0] ra;
    rst = 1'b1; valid_a = 1'b0; valid_b = 1'b0; sel = 0;
    addr = '0; write = 1'b0; wdata = '0; wstrb = '0;
    mst_ready = '0; mst_rdata = '0; mst_error = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      sel = i; #1;
      chk("reset_ready", 64'(o_rdy), 64'd0);
      chk("reset_rdata", 64'(o_rd), 64'd0);
      chk("reset_error", 64'(o_err), 64'd0);
      chk("reset_valid", 64'(o_mv), 64'd0);
      chk("reset_addr", 64'(o_ma), 64'd0);
    end
    @(negedge clk); rst = 1'b0;

    xact(0, 48'h20020004, 1'b0, 32'h0, 4'h0, 0, 32'h12345678, 1'b0);
    xact(0, 48'h200A0010, 1'b1, 32'hA5A5A5A5, 4'hF, 4, 32'h0, 1'b0);
    xact(0, 48'h200C0000, 1'b0, 32'h0, 4'h0, 0, 32'h0, 1'b0);
    xact(1, 48'h200A0000, 1'b0, 32'h0, 4'h0, 0, 32'h11111111, 1'b0);
    xact(1, 48'h200B0000, 1'b0, 32'h0, 4'h0, 1, 32'hCAFEF00D, 1'b1);
    xact(0, 48'h20010FFC, 1'b1, 32'h01020304, 4'h3, 2, 32'h0, 1'b0);
    xact(0, 48'h20011000, 1'b0, 32'h0, 4'h0, 0, 32'h0, 1'b0);
`ifdef CARFIELD_REGBUS_TIMEOUT_EN
    xact(1, 48'h20010000, 1'b0, 32'h0, 4'h0, 1000, 32'h0, 1'b0);
    xact(1, 48'h20010004, 1'b0, 32'h0, 4'h0, 15, 32'h600DF00D, 1'b0);
`else
    xact(1, 48'h20010000, 1'b0, 32'h0, 4'h0, 20, 32'h600DF00D, 1'b0);
`endif

    // Reset in the middle of a forward phase.
    sel = 0;
    @(negedge clk);
    addr = 48'h20020000; write = 1'b0; valid_a = 1'b1;
    @(posedge clk); #1;
    chk("rst_fwd_valid", 64'(o_mv), 64'h2);
    @(posedge clk); #1;
    rst = 1'b1; #1;
    chk("rst_valid_clr", 64'(o_mv), 64'd0);
    chk("rst_ready_clr", 64'(o_rdy), 64'd0);
    chk("rst_error_clr", 64'(o_err), 64'd0);
    valid_a = 1'b0;
    @(negedge clk); rst = 1'b0;
    xact(0, 48'h20010000, 1'b0, 32'h0, 4'h0, 0, 32'h87654321, 1'b0);

    for (int n = 0; n < 40; n++) begin
      d = int'($urandom_range(0, 1));
      p = int'($urandom_range(0, 3));
      kind = int'($urandom_range(0, 4));
      case (kind)
        0, 1: ra = AW'(base_t[p] + 64'($urandom_range(0, 1023)) * 4);
        2:    ra = AW'(base_t[p] + 64'hFFC);
        3:    ra = AW'(base_t[p] + 64'h1000);
        default: ra = {16'($urandom), $urandom};
      endcase
      xact(d, ra, 1'($urandom), $urandom, 4'($urandom), int'($urandom_range(0, 5)),
           $urandom, 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
